nibble_add_sequencer: RTL and testbench



---
 rtl/nibble_seq_pkg.sv | 16 +
 rtl/reversible_4bit_adder.sv | 29 ++
 rtl/nibble_add_sequencer.sv | 130 +++++++++++++
 tb/tb_nibble_add_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_seq_pkg.sv
// Shared types and constants for the nibble-serial add/sub sequencer.
// Imported by the sequencer and its datapath.
package nibble_seq_pkg;

  localparam int NIB_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/reversible_4bit_adder.sv
// 4-bit ripple adder built from Peres-style sum/carry stages.
// The ancilla input is XORed into the carry-out and must be 0 for a plain add.
module reversible_4bit_adder
  import nibble_seq_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  input  logic             anc,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  logic [NIB_W:0] c;

  // Ripple the carry through one Peres stage per bit.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < NIB_W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) ^ (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[NIB_W] ^ anc;

endmodule

// File: rtl/nibble_add_sequencer.sv
// Multi-cycle W-bit add/sub that reuses one 4-bit adder per nibble,
// LSB nibble first, with the carry held in a register between nibbles.
module nibble_add_sequencer
  import nibble_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NIB_W*NIBBLES-1:0] in_a,
  input  logic [NIB_W*NIBBLES-1:0] in_b,
  input  logic                     in_cin,
  input  logic                     in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NIB_W*NIBBLES-1:0] out_sum,
  output logic                     out_cout,
  output logic                     out_ovf
);

  localparam int W  = NIB_W * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;

  int unsigned      base;
  logic [NIB_W-1:0] nib_a;
  logic [NIB_W-1:0] nib_b;
  logic [NIB_W-1:0] nib_s;
  logic             nib_c;

  assign base  = NIB_W * 32'(idx_q);
  assign nib_a = a_q[base +: NIB_W];
  assign nib_b = b_q[base +: NIB_W];

  reversible_4bit_adder u_add (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .anc  (1'b0),
    .sum  (nib_s),
    .cout (nib_c)
  );

  // Next-state logic: accept in IDLE, one nibble per RUN cycle, hold in DONE.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = in_a;
          b_d        = (in_op == OP_SUB) ? ~in_b : in_b;
          carry_d    = (in_op == OP_SUB) ? 1'b1 : in_cin;
          idx_d      = '0;
          state_d    = RUN;
          in_ready_d = 1'b0;
        end
      end
      RUN: begin
        sum_d[base +: NIB_W] = nib_s;
        carry_d              = nib_c;
        if (idx_q == LAST) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = carry_q;
  assign out_ovf   = (a_q[W-1] == b_q[W-1]) && (sum_q[W-1] != a_q[W-1]);

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Scoreboard bench: directed cases on NIBBLES=4, random sweeps on 2 and 8.
// Expected results are queued at drive time and popped at the output handshake.
module tb_nibble_add_sequencer;
  import nibble_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] ref_op(int w, logic [31:0] a,
                                         logic [31:0] b, logic cin,
                                         logic op);
    logic [32:0] mask, be, full;
    logic [31:0] s;
    logic        c, co, ov;
    mask = (33'h1 << w) - 33'h1;
    be   = op ? (~{1'b0, b} & mask) : ({1'b0, b} & mask);
    c    = op ? 1'b1 : cin;
    full = ({1'b0, a} & mask) + be + {32'b0, c};
    s    = full[31:0] & mask[31:0];
    co   = full[w];
    ov   = (a[w-1] == be[w-1]) && (s[w-1] != a[w-1]);
    return {ov, co, s};
  endfunction

  function automatic logic [33:0] mk(logic ov, logic co, logic [31:0] s);
    return {ov, co, s};
  endfunction

  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_cin = 1'b0;
  logic        in_op = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic [33:0] q4[$];

  nibble_add_sequencer #(.NIBBLES(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  function automatic logic [33:0] obs4();
    return {out_ovf, out_cout, 16'h0, out_sum};
  endfunction

  task automatic wait_done4(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic op4(string tag, logic [15:0] a, logic [15:0] b,
                     logic cin, logic op, logic [33:0] exp);
    int lat;
    logic [33:0] e;
    in_a = a; in_b = b; in_cin = cin; in_op = op;
    in_valid = 1'b1;
    q4.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_done4(lat);
    check_eq({tag, "_lat"}, 64'(lat), 64'd5);
    e = q4.pop_front();
    check_eq(tag, 64'(obs4()), 64'(e));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_rel"}, 64'({out_valid, in_ready}), 64'(2'b01));
  endtask

  for (genvar g = 0; g < 2; g++) begin : sw
    localparam int N = (g == 0) ? 2 : 8;
    localparam int W = 4 * N;
    logic         rst_s = 1'b1;
    logic         iv = 1'b0;
    logic         ir;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         op = 1'b0;
    logic         ov;
    logic         ordy = 1'b0;
    logic [W-1:0] s;
    logic         co;
    logic         of;
    logic [33:0]  q[$];
    logic         done = 1'b0;

    nibble_add_sequencer #(.NIBBLES(N)) u_dut (
      .clk       (clk),
      .rst       (rst_s),
      .in_valid  (iv),
      .in_ready  (ir),
      .in_a      (a),
      .in_b      (b),
      .in_cin    (cin),
      .in_op     (op),
      .out_valid (ov),
      .out_ready (ordy),
      .out_sum   (s),
      .out_cout  (co),
      .out_ovf   (of)
    );

    initial begin
      int          lat;
      logic [31:0] ra, rb;
      logic [33:0] e, got;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_s = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        ra  = $urandom;
        rb  = $urandom;
        a   = ra[W-1:0];
        b   = rb[W-1:0];
        cin = 1'($urandom_range(0, 1));
        op  = 1'($urandom_range(0, 1));
        iv  = 1'b1;
        q.push_back(ref_op(W, 32'(a), 32'(b), cin, op));
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        iv = 1'b0;
        while (!ov && lat < 40) begin
          @(posedge clk);
          lat++;
          @(negedge clk);
        end
        check_eq($sformatf("sw%0d_lat", N), 64'(lat), 64'(N + 1));
        repeat ($urandom_range(0, 2)) @(negedge clk);
        got        = '0;
        got[W-1:0] = s;
        got[32]    = co;
        got[33]    = of;
        e = q.pop_front();
        check_eq($sformatf("sw%0d_res%0d", N, i), 64'(got), 64'(e));
        ordy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy = 1'b0;
      end
      done = 1'b1;
    end
  end

  initial begin
    int          lat;
    logic [33:0] e;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_state",
             64'({in_ready, out_valid, out_cout, out_ovf, out_sum}),
             64'({1'b1, 1'b0, 1'b0, 1'b0, 16'h0}));

    op4("add", 16'h1234, 16'h4321, 1'b0, OP_ADD, mk(1'b0, 1'b0, 32'h5555));
    op4("ripple", 16'hFFFF, 16'h0001, 1'b0, OP_ADD, mk(1'b0, 1'b1, 32'h0000));
    op4("ovf", 16'h7FFF, 16'h0001, 1'b0, OP_ADD, mk(1'b1, 1'b0, 32'h8000));
    op4("sub_neg", 16'h0005, 16'h0007, 1'b1, OP_SUB, mk(1'b0, 1'b0, 32'hFFFE));
    op4("sub_pos", 16'h0007, 16'h0005, 1'b1, OP_SUB, mk(1'b0, 1'b1, 32'h0002));

    in_a = 16'h0100; in_b = 16'h0200; in_cin = 1'b0; in_op = OP_ADD;
    in_valid = 1'b1;
    q4.push_back(mk(1'b0, 1'b0, 32'h0300));
    @(posedge clk);
    @(negedge clk);
    in_a = 16'hAAAA; in_b = 16'h5555; in_op = OP_SUB;
    wait_done4(lat);
    check_eq("bp_lat", 64'(lat), 64'd5);
    e = q4.pop_front();
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("bp_hold%0d", i), 64'(obs4()), 64'(e));
      check_eq($sformatf("bp_rdy%0d", i), 64'({out_valid, in_ready}),
               64'(2'b10));
      @(posedge clk);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("bp_rel", 64'({out_valid, in_ready}), 64'(2'b01));
    @(posedge clk);
    @(negedge clk);
    check_eq("bp_noacc", 64'({out_valid, in_ready}), 64'(2'b01));

    in_a = 16'h0F0F; in_b = 16'h0101; in_op = OP_ADD;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort",
             64'({in_ready, out_valid, out_cout, out_ovf, out_sum}),
             64'({1'b1, 1'b0, 1'b0, 1'b0, 16'h0}));
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("abort_quiet", 64'({out_valid, in_ready}), 64'(2'b01));
    end
    op4("post_rst", 16'h0001, 16'h0001, 1'b0, OP_ADD, mk(1'b0, 1'b0, 32'h0002));
    check_eq("q4_empty", 64'(q4.size()), 64'd0);

    for (int i = 0; i < 100000 && !(sw[0].done && sw[1].done); i++)
      @(posedge clk);
    check_eq("sweep_done", 64'({sw[0].done, sw[1].done}), 64'(2'b11));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
